// File: rtl/config_stream_loader.sv
// config_stream_loader
//   Shifts a (length, type) header in on tdi, MSB first, then streams cfg_length
//   payload words of WORD_W bits to a consumer over a one-entry valid/ready buffer.
//   tdo gives the chained TDR path a one-clock tdi bypass while shifting.
//
// Ports
//   clk, rst      TCK-domain clock, asynchronous active-high reset
//   en, tdi       shift enable and serial data (MSB first)
//   tdo           tdi delayed one clock while shifting, else 0
//   cfg_type      last captured type field (header LSBs)
//   cfg_length    last captured length field in words (header MSBs)
//   hdr_valid     one-cycle pulse after header capture
//   word_data     buffered payload word, MSB = first bit received
//   word_valid    word_data holds an unconsumed word
//   word_ready    consumer accepts the word when word_valid & word_ready
//   busy          header or payload shifting in progress
//   done          all words received; held until en drops
//   err_overflow  sticky: a word completed while the buffer was still full
module config_stream_loader #(
  parameter int unsigned TYPE_W = 4,
  parameter int unsigned LEN_W  = 12,
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tdi,
  output logic              tdo,
  output logic [TYPE_W-1:0] cfg_type,
  output logic [LEN_W-1:0]  cfg_length,
  output logic              hdr_valid,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done,
  output logic              err_overflow
);

  localparam int unsigned HDR_W     = TYPE_W + LEN_W;
  localparam int unsigned MAX_BITS  = (HDR_W > WORD_W) ? HDR_W : WORD_W;
  localparam int unsigned CNT_W     = $clog2(MAX_BITS + 1);
  // Shift registers hold only the bits before the one arriving on tdi.
  localparam int unsigned WORD_SR_W = (WORD_W > 1) ? WORD_W - 1 : 1;

  typedef enum logic [1:0] {StIdle, StHeader, StPayload, StDone} state_e;

  state_e state_q, state_d;

  logic [HDR_W-2:0]     hdr_sr_q, hdr_sr_d;
  logic [WORD_SR_W-1:0] word_sr_q, word_sr_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]     word_cnt_q, word_cnt_d;
  logic [TYPE_W-1:0]    cfg_type_q, cfg_type_d;
  logic [LEN_W-1:0]     cfg_length_q, cfg_length_d;
  logic                 hdr_valid_q, hdr_valid_d;
  logic [WORD_W-1:0]    word_data_q, word_data_d;
  logic                 word_valid_q, word_valid_d;
  logic                 err_q, err_d;
  logic                 tdo_q, tdo_d;

  // Header/word as they would look including the bit on tdi this cycle.
  logic [HDR_W-1:0]  hdr_full;
  logic [WORD_W-1:0] word_full;
  logic              hdr_last;
  logic              word_last;
  logic [LEN_W-1:0]  word_cnt_inc;
  logic              last_word;

  assign hdr_full = {hdr_sr_q, tdi};

  if (WORD_W > 1) begin : g_word_multi
    assign word_full = {word_sr_q, tdi};
  end else begin : g_word_single
    assign word_full = tdi;
  end

  assign hdr_last     = (bit_cnt_q == CNT_W'(HDR_W - 1));
  assign word_last    = (bit_cnt_q == CNT_W'(WORD_W - 1));
  assign word_cnt_inc = word_cnt_q + LEN_W'(1);
  assign last_word    = (word_cnt_inc == cfg_length_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StHeader;
      end
      StHeader: begin
        if (!en) begin
          state_d = StIdle;
        end else if (hdr_last) begin
          state_d = (hdr_full[HDR_W-1:TYPE_W] == '0) ? StDone : StPayload;
        end
      end
      StPayload: begin
        if (!en) begin
          state_d = StIdle;
        end else if (word_last && last_word) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StHeader, StPayload: busy = 1'b1;
      StDone:              done = 1'b1;
      default:             ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    hdr_sr_d     = hdr_sr_q;
    word_sr_d    = word_sr_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    cfg_type_d   = cfg_type_q;
    cfg_length_d = cfg_length_q;
    hdr_valid_d  = 1'b0;
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    err_d        = err_q;
    tdo_d        = 1'b0;

    // The buffer drains in every state; a load below overrides the clear.
    if (word_valid_q && word_ready) word_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          tdo_d       = tdi;
          hdr_sr_d    = '0;
          hdr_sr_d[0] = tdi;
          bit_cnt_d   = CNT_W'(1);
          err_d       = 1'b0;
        end
      end
      StHeader: begin
        tdo_d = tdi;
        if (!en) begin
          hdr_sr_d  = '0;
          bit_cnt_d = '0;
        end else if (hdr_last) begin
          cfg_type_d   = hdr_full[TYPE_W-1:0];
          cfg_length_d = hdr_full[HDR_W-1:TYPE_W];
          hdr_valid_d  = 1'b1;
          hdr_sr_d     = '0;
          bit_cnt_d    = '0;
          word_sr_d    = '0;
          word_cnt_d   = '0;
        end else begin
          hdr_sr_d  = hdr_full[HDR_W-2:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      StPayload: begin
        tdo_d = tdi;
        if (!en) begin
          word_sr_d  = '0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end else if (word_last) begin
          word_sr_d  = '0;
          bit_cnt_d  = '0;
          word_cnt_d = word_cnt_inc;
          if (!word_valid_q || word_ready) begin
            word_data_d  = word_full;
            word_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          word_sr_d = word_full[WORD_SR_W-1:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        if (!en) word_cnt_d = '0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_sr_q     <= '0;
      word_sr_q    <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      cfg_type_q   <= '0;
      cfg_length_q <= '0;
      hdr_valid_q  <= 1'b0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
      tdo_q        <= 1'b0;
    end else begin
      hdr_sr_q     <= hdr_sr_d;
      word_sr_q    <= word_sr_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      cfg_type_q   <= cfg_type_d;
      cfg_length_q <= cfg_length_d;
      hdr_valid_q  <= hdr_valid_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
      tdo_q        <= tdo_d;
    end
  end

  assign tdo          = tdo_q;
  assign cfg_type     = cfg_type_q;
  assign cfg_length   = cfg_length_q;
  assign hdr_valid    = hdr_valid_q;
  assign word_data    = word_data_q;
  assign word_valid   = word_valid_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_config_stream_loader.sv
module tb_config_stream_loader;

  localparam int TW = 4;
  localparam int LW = 12;
  localparam int WW = 8;
  localparam int HW = TW + LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          tdi;
  logic          tdo;
  logic [TW-1:0] cfg_type;
  logic [LW-1:0] cfg_length;
  logic          hdr_valid;
  logic [WW-1:0] word_data;
  logic          word_valid;
  logic          word_ready;
  logic          busy;
  logic          done;
  logic          err_overflow;

  int checks = 0;
  int errors = 0;

  config_stream_loader #(.TYPE_W(TW), .LEN_W(LW), .WORD_W(WW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .tdi          (tdi),
    .tdo          (tdo),
    .cfg_type     (cfg_type),
    .cfg_length   (cfg_length),
    .hdr_valid    (hdr_valid),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .busy         (busy),
    .done         (done),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: tracks a session as the list of bits received so far.
  // Header = first HW bits, word k = bits HW+k*WW .. HW+(k+1)*WW-1.
  bit            m_in;
  bit            m_hdr;
  int            m_n;
  int            m_total;
  bit            q_bits[$];
  logic          e_tdo;
  logic [TW-1:0] e_type;
  logic [LW-1:0] e_len;
  logic          e_hv;
  logic [WW-1:0] e_wd;
  logic          e_wv;
  logic          e_err;

  function automatic bit m_done();
    return m_in && m_hdr && (m_n == m_total);
  endfunction

  function automatic int pack(input int start, input int count);
    int v = 0;
    for (int i = 0; i < count; i++) v = v * 2 + int'(q_bits[start + i]);
    return v;
  endfunction

  task automatic model_reset();
    m_in = 0; m_hdr = 0; m_n = 0; m_total = 0; q_bits.delete();
    e_tdo = 0; e_type = '0; e_len = '0; e_hv = 0; e_wd = '0; e_wv = 0; e_err = 0;
  endtask

  task automatic model_step(input logic e, input logic d, input logic r);
    bit was_done = m_done();
    bit accept   = e_wv && r;
    bit loaded   = 0;
    int v;
    logic [WW-1:0] neww = '0;
    e_tdo = ((!m_in && e) || (m_in && !was_done)) ? d : 1'b0;
    e_hv  = 0;
    if (!m_in) begin
      if (e) begin
        m_in = 1; m_hdr = 0; q_bits.delete(); q_bits.push_back(d); m_n = 1; e_err = 0;
      end
    end else if (was_done || !e) begin
      if (!e) m_in = 0;
    end else begin
      q_bits.push_back(d);
      m_n++;
      if (m_n == HW) begin
        v       = pack(0, HW);
        e_type  = TW'(v % (1 << TW));
        e_len   = LW'(v / (1 << TW));
        e_hv    = 1;
        m_hdr   = 1;
        m_total = HW + int'(e_len) * WW;
      end else if (m_n > HW && ((m_n - HW) % WW) == 0) begin
        neww = WW'(pack(m_n - WW, WW));
        if (!e_wv || r) loaded = 1;
        else e_err = 1;
      end
    end
    if (loaded) begin
      e_wv = 1; e_wd = neww;
    end else if (accept) begin
      e_wv = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("tdo", 32'(tdo), 32'(e_tdo));
    check("cfg_type", 32'(cfg_type), 32'(e_type));
    check("cfg_length", 32'(cfg_length), 32'(e_len));
    check("hdr_valid", 32'(hdr_valid), 32'(e_hv));
    check("word_data", 32'(word_data), 32'(e_wd));
    check("word_valid", 32'(word_valid), 32'(e_wv));
    check("busy", 32'(busy), 32'(m_in && !m_done()));
    check("done", 32'(done), 32'(m_done()));
    check("err_overflow", 32'(err_overflow), 32'(e_err));
  endtask

  task automatic cycle(input logic e, input logic d, input logic r);
    en = e; tdi = d; word_ready = r;
    @(posedge clk);
    model_step(e, d, r);
    #1;
    check_all();
  endtask

  function automatic logic rdy_sel(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return logic'($urandom % 2);
  endfunction

  // Shift nbits of v, MSB first, with en high.
  task automatic send(input logic [31:0] v, input int nbits, input int rdy_mode);
    for (int i = nbits - 1; i >= 0; i--) cycle(1'b1, v[i], rdy_sel(rdy_mode));
  endtask

  initial begin
    logic [15:0] hdr;
    logic [31:0] pay;
    int          len;
    int          nbits;
    int          cut;

    rst = 1'b1; en = 1'b0; tdi = 1'b0; word_ready = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Nominal: type 5, length 2, payload A5 3C, consumer always ready.
    send(32'h0025, 16, 1);
    send(32'hA5, 8, 1);
    send(32'h3C, 8, 1);
    check("t1_type", 32'(cfg_type), 32'd5);
    check("t1_len", 32'(cfg_length), 32'd2);
    check("t1_done", 32'(done), 32'd1);
    check("t1_err", 32'(err_overflow), 32'd0);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Zero length goes straight to done.
    send(32'h0003, 16, 1);
    check("t2_done", 32'(done), 32'd1);
    check("t2_hv", 32'(hdr_valid), 32'd1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Consumer stalled: second word overflows.
    send(32'h0021, 16, 0);
    send(32'h11, 8, 0);
    send(32'h22, 8, 0);
    check("t3_data", 32'(word_data), 32'h11);
    check("t3_valid", 32'(word_valid), 32'd1);
    check("t3_err", 32'(err_overflow), 32'd1);
    check("t3_done", 32'(done), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // Accept and reload on the same edge.
    send(32'h0022, 16, 0);
    send(32'h11, 8, 0);
    send(32'h22 >> 1, 7, 0);
    cycle(1'b1, 1'b0, 1'b1);
    check("t4_data", 32'(word_data), 32'h22);
    check("t4_valid", 32'(word_valid), 32'd1);
    check("t4_err", 32'(err_overflow), 32'd0);
    cycle(1'b0, 1'b0, 1'b1);

    // Abort after 10 header bits, then a clean header.
    send(32'h03FF, 10, 2);
    cycle(1'b0, 1'b0, 1'b1);
    check("t5_type_keep", 32'(cfg_type), 32'd2);
    check("t5_len_keep", 32'(cfg_length), 32'd2);
    send(32'h0017, 16, 1);
    check("t5_type", 32'(cfg_type), 32'd7);
    check("t5_len", 32'(cfg_length), 32'd1);
    send(32'h5A, 8, 1);
    check("t5_data", 32'(word_data), 32'h5A);
    cycle(1'b0, 1'b0, 1'b1);

    // Async reset mid-payload with a word buffered.
    send(32'h0022, 16, 0);
    send(32'hC3, 8, 0);
    send(32'h5, 3, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("t6_valid", 32'(word_valid), 32'd0);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Randomized sessions with random readiness and occasional aborts.
    for (int s = 0; s < 60; s++) begin
      len   = int'($urandom % 4);
      hdr   = {LW'(len), TW'($urandom % 16)};
      pay   = $urandom;
      nbits = HW + len * WW;
      cut   = (($urandom % 6) == 0) ? int'($urandom % nbits) : nbits;
      for (int i = 0; i < cut; i++) begin
        if (i < HW) cycle(1'b1, hdr[HW - 1 - i], rdy_sel(2));
        else cycle(1'b1, pay[(i - HW) % 32], rdy_sel(2));
      end
      for (int k = 0; k < int'($urandom % 3); k++) cycle(1'b1, logic'($urandom % 2), rdy_sel(2));
      for (int k = 0; k <= int'($urandom % 2); k++) cycle(1'b0, logic'($urandom % 2), rdy_sel(2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_stream_loader.md
Name: config_stream_loader

Overview:
- Parametrised successor of the JTAG-side config header shifter.
- Serially shifts in a header (type + length) on tdi, MSB first, then streams `cfg_length` payload words of WORD_W bits each to a downstream consumer over a valid/ready handshake.
- Sits between the JTAG TDR path and the bitstream decrypt/config fabric. Provides a one-cycle TDI-to-TDO bypass so chained TDRs keep working.

Parameters:
TYPE_W, 4, width of config type field (header LSBs)
LEN_W, 12, width of length field in words (header MSBs)
WORD_W, 8, payload word width in bits; must be >= 1

Ports:
clk  in  1  TCK-domain clock
rst  in  1  asynchronous active-high reset
en  in  1  shift enable; header/payload bit on tdi sampled each clk while high
tdi  in  1  serial data in, MSB first
tdo  out  1  tdi delayed one clk while busy, else 0
cfg_type  out  TYPE_W  last captured type
cfg_length  out  LEN_W  last captured length (words)
hdr_valid  out  1  one-cycle pulse after header capture
word_data  out  WORD_W  buffered payload word, MSB = first bit received
word_valid  out  1  word_data holds an unconsumed word
word_ready  in  1  consumer accepts word when word_valid & word_ready
busy  out  1  state is HEADER or PAYLOAD
done  out  1  all cfg_length words received; held until en drops
err_overflow  out  1  sticky: a word completed while the buffer was still full

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; shift regs, bit/word counters 0.
- HDR_W = TYPE_W+LEN_W. Header shift reg is HDR_W wide; shift is {sr[HDR_W-2:0], tdi}.
- IDLE: en=1 -> sample tdi as header bit 1, clear bit counter to 1, clear err_overflow, go HEADER. en=0 -> stay.
- HEADER: each en=1 edge shifts one bit. On the edge sampling bit HDR_W:
  - cfg_type <= full[TYPE_W-1:0]
  - cfg_length <= full[HDR_W-1:TYPE_W]
  - hdr_valid = 1 for the following cycle only
  - if length == 0 -> DONE, else -> PAYLOAD with word count 0
- PAYLOAD: each en=1 edge shifts one bit into a WORD_W word shift reg. On the edge sampling bit WORD_W of a word:
  - if buffer empty, or word_valid & word_ready in the same cycle: word_data <= assembled word, word_valid = 1
  - else: word dropped, err_overflow <= 1
  - word count increments in both cases (width LEN_W, no wrap, since count <= length)
  - when count reaches cfg_length -> DONE
- Handshake: word_valid clears on the edge where word_valid & word_ready, unless a new word loads on the same edge, in which case it stays 1 with new data. word_data is stable while word_valid=1 and not accepted.
- DONE: done=1. While en=1, tdi is ignored and no further shifting occurs. en=0 -> IDLE, done cleared next edge.
- en=0 in HEADER or PAYLOAD (abort):
  - go IDLE; partial header and partial word discarded; counters cleared
  - cfg_type/cfg_length keep prior values
  - a buffered word stays valid until consumed
- tdo: registered copy of tdi on every edge where state (before edge) is IDLE-with-en, HEADER or PAYLOAD; 0 otherwise. Latency 1 clk.
- Buffer drain in any state: word_valid & word_ready always clears the buffer.
- rst asserted mid-operation: immediate return to reset values, including a buffered word and err_overflow.

Test Plan:
- Header 16'h0025 (MSB first, en high 16 cycles), then payload 0xA5, 0x3C, word_ready=1 -> cfg_type=5, cfg_length=2, hdr_valid one pulse; word_valid pulses with 0xA5 then 0x3C; done=1 after 32nd bit; err_overflow=0.
- Header 16'h0003 (length 0, type 3) -> hdr_valid pulse, done=1 on next cycle, word_valid never asserts.
- Header length 2, word_ready=0 throughout, payload 0x11, 0x22 -> word_data stays 0x11, word_valid=1, err_overflow=1 after 2nd word; done=1.
- Header length 2, word_ready asserted exactly on the cycle the 2nd word completes -> word_data becomes 0x22, word_valid stays 1, err_overflow=0.
- en dropped after 10 header bits, then full header 16'h0017 -> cfg_* unchanged after abort; then type=7, length=1; no stale bits mixed in.
- rst pulsed mid-PAYLOAD with word_valid=1 -> all outputs 0 asynchronously; tdo tracks tdi with 1-clk delay in a normal header shift.
